// File: rtl/fpmul_result_checker_if.sv
// Bus between the FP multiplier bench stimulus/DUT and the result checker.
// master: vector source side (drives vin/last/exp_z/fp_z, observes results)
// slave : checker side (samples the vector stream, drives comparison results)
//   vin, last      vector applied this cycle / it is the final one
//   exp_z, fp_z    golden product for the applied vector / DUT result
//   cmp_valid      one-cycle pulse per compared vector, mismatch qualifies it
//   vec_cnt        saturating count of compared vectors
//   err_cnt        saturating count of mismatches
//   first_err_*    index, DUT value and golden value of the first mismatch
//   done, pass     final vector compared / and no mismatches seen
interface fpmul_result_checker_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) ();

  logic             vin;
  logic             last;
  logic [WIDTH-1:0] exp_z;
  logic [WIDTH-1:0] fp_z;

  logic             cmp_valid;
  logic             mismatch;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_err_idx;
  logic [WIDTH-1:0] first_err_got;
  logic [WIDTH-1:0] first_err_exp;
  logic             done;
  logic             pass;

  modport master (
    output vin, last, exp_z, fp_z,
    input  cmp_valid, mismatch, vec_cnt, err_cnt,
    input  first_err_idx, first_err_got, first_err_exp, done, pass
  );

  modport slave (
    input  vin, last, exp_z, fp_z,
    output cmp_valid, mismatch, vec_cnt, err_cnt,
    output first_err_idx, first_err_got, first_err_exp, done, pass
  );

endinterface

// File: rtl/fpmul_result_checker.sv
// Response checker for the FP multiplier bench. Every applied vector's golden
// product is delayed by the DUT pipeline latency and compared with the DUT
// result. Counts vectors and mismatches, captures the first failure and
// reports done/pass once the vector marked last has been compared.
// Ports:
//   clk  rising-edge clock shared with the DUT
//   rst  asynchronous active-high reset
//   bus  fpmul_result_checker_if.slave (vector stream in, results out)
module fpmul_result_checker #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned CNT_W   = 16,
  parameter bit          NAN_EQ  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  fpmul_result_checker_if.slave   bus
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = WIDTH - EXP_W - 1;
  localparam int unsigned TAIL   = LATENCY - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             last;
    logic [WIDTH-1:0] exp;
  } entry_t;

  state_t state_q, state_d;

  entry_t dl [LATENCY];
  logic   hold_c;

  logic             cmp_valid_q, cmp_valid_d;
  logic             mismatch_q,  mismatch_d;
  logic [CNT_W-1:0] vec_cnt_q,   vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic             done_q,      done_d;
  logic             pass_q,      pass_d;

  logic do_cmp_c;
  logic match_c;

  // IEEE-754 NaN: all-ones exponent with a nonzero mantissa
  function automatic logic is_nan(input logic [WIDTH-1:0] x);
    return (x[WIDTH-2 -: EXP_W] == {EXP_W{1'b1}}) && (x[MANT_W-1:0] != '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_W'(1);
  endfunction

  // Once done, the delay line is frozen so nothing further reaches the tail
  assign hold_c = (state_q == ST_DONE);

  // Delay line head: loads the vector presented this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl[0] <= '0;
    end else if (!hold_c) begin
      dl[0] <= '{valid: bus.vin, last: bus.vin & bus.last, exp: bus.exp_z};
    end
  end

  // Delay line body: one stage per remaining cycle of DUT latency
  for (genvar g = 1; g < LATENCY; g++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dl[g] <= '0;
      end else if (!hold_c) begin
        dl[g] <= dl[g-1];
      end
    end
  end

  // Tail entry lines up with the DUT result of the same vector
  assign do_cmp_c = !hold_c && dl[TAIL].valid;
  assign match_c  = (dl[TAIL].exp == bus.fp_z) ||
                    (NAN_EQ && is_nan(dl[TAIL].exp) && is_nan(bus.fp_z));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    cmp_valid_d = 1'b0;
    mismatch_d  = 1'b0;
    vec_cnt_d   = vec_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_idx_d = first_idx_q;
    first_got_d = first_got_q;
    first_exp_d = first_exp_q;
    done_d      = done_q;
    pass_d      = pass_q;

    case (state_q)
      ST_IDLE: if (bus.vin) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    if (do_cmp_c) begin
      cmp_valid_d = 1'b1;
      mismatch_d  = !match_c;
      vec_cnt_d   = sat_inc(vec_cnt_q);
      if (!match_c) begin
        err_cnt_d = sat_inc(err_cnt_q);
        // Saturated err_cnt never returns to zero, so capture happens once
        if (err_cnt_q == '0) begin
          first_idx_d = vec_cnt_q;
          first_got_d = bus.fp_z;
          first_exp_d = dl[TAIL].exp;
        end
      end
      if (dl[TAIL].last) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        pass_d  = (err_cnt_d == '0);
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      vec_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      first_got_q <= '0;
      first_exp_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      cmp_valid_q <= cmp_valid_d;
      mismatch_q  <= mismatch_d;
      vec_cnt_q   <= vec_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_idx_q <= first_idx_d;
      first_got_q <= first_got_d;
      first_exp_q <= first_exp_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.cmp_valid     = cmp_valid_q;
  assign bus.mismatch      = mismatch_q;
  assign bus.vec_cnt       = vec_cnt_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_idx = first_idx_q;
  assign bus.first_err_got = first_got_q;
  assign bus.first_err_exp = first_exp_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;

endmodule
